mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side responder for the multicycle CPU's memory interface.
- Accepts one read or write request at a time over a req/ack handshake and serves it after a programmable number of wait states.
- Supports word, halfword and byte writes through byte-lane enables, and flags misaligned or out-of-range accesses.
- Sits between the CPU datapath (address/store-data path) and word-organised storage. It replaces the zero-wait-state memory model when stalling behaviour must be exercised.

Parameters:
- DEPTH, 256, number of 32-bit words of storage. Must be a power of two.
- LATENCY, 2, wait-state cycles inserted between request acceptance and ack. Range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  request strobe. Sampled only in IDLE.
- wr  input  1  1 = write, 0 = read. Sampled with req.
- size  input  2  access size: 00 word, 01 halfword, 10 byte, 11 reserved.
- addr  input  32  byte address, big-endian lane order.
- wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- rdata  output  32  aligned word containing addr. Valid while ack=1, held until the next ack.
- ack  output  1  one-cycle pulse: request completed.
- err  output  1  one-cycle pulse coincident with ack: request rejected.
- busy  output  1  high from the cycle after acceptance until ack, inclusive.

Behaviour:
- Reset (async, rst=1): state IDLE; ack=0, err=0, busy=0, rdata=0, wait counter=0. Storage contents are not cleared.
- States:
  - IDLE: on req=1, latch wr/size/addr/wdata, load counter with LATENCY, go to WAIT. If LATENCY=0, go directly to ACCESS.
  - WAIT: decrement counter each cycle; when counter reaches 1, go to ACCESS.
  - ACCESS: perform the check and access; drive ack=1 (and err if rejected); go to IDLE.
- Latency: ack is high exactly LATENCY+1 cycles after the edge on which req was sampled. Back-to-back throughput is one request per LATENCY+2 cycles.
- req is ignored while busy. The requester holds nothing after acceptance; all operands are latched at acceptance.
- Lane mapping (big-endian):
  - addr[1:0]=0 selects byte [31:24], 3 selects [7:0].
  - Halfword addr[1]=0 selects [31:16], 1 selects [15:0].
- Write: updates only the enabled lanes of word addr[log2(DEPTH)+1:2]; other lanes are unchanged. rdata returns the pre-write word.
- Read: rdata = full stored word; extension and selection happen in the CPU's load path.
- Error conditions (err=1, ack=1, no storage change, rdata unchanged):
  - size=11.
  - word with addr[1:0]!=0.
  - half with addr[0]=1.
  - addr[31:log2(DEPTH)+2] != 0.
- Reset asserted mid-request: request abandoned, no write performed, no ack. A pending write is never partially applied, because the write occurs only in ACCESS.
- req held high continuously: a new request is accepted on the first IDLE cycle after each ack.

Decomposition:
- Shared package:
  - size encodings SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10.
  - state encodings S_IDLE, S_WAIT, S_ACCESS.
  - lane-enable constant widths.
- One natural sub-module: mem_lane_decode (combinational). Inputs size and addr[1:0]; outputs 4-bit byte-enable, the lane-aligned write word from wdata, and the misalign flag.
- The FSM, counter and storage array stay in mem_responder.

Test Plan:
- LATENCY=2; write word 0xDEADBEEF to addr 0x10, then read 0x10 -> first ack 3 cycles after req, err=0; read returns rdata=0xDEADBEEF; busy high 3 cycles per request.
- Byte write 0x000000AA to addr 0x11 over word 0x11223344 -> read of 0x10 returns 0x11AA3344; halfword write 0x5566 to 0x12 then gives 0x11AA5566.
- Word access at addr 0x13, half at 0x11, size=11 at 0x10 -> each gives ack=1, err=1; word 0x10 still reads 0x11AA5566.
- DEPTH=256, addr 0x400 -> err=1; addr 0x3FC write 0x12345678 -> err=0, readback 0x12345678.
- rst pulsed 1 cycle into WAIT of a write of 0xFFFFFFFF to 0x20 (prior value 0x0) -> no ack; ack/rdata/busy=0 immediately; read of 0x20 after reset returns 0x00000000.
- LATENCY=0 with req held high for 3 reads -> ack every 2nd cycle; requests arriving while busy are never double-served.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared encodings for the wait-state memory responder.
//   Provides the access-size codes, the FSM state type, the byte-lane enable
//   type and a helper that expands lane enables into a 32-bit bit mask.
package mem_responder_pkg;
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;
    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    typedef logic [LANES-1:0] be_t;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;
    function automatic logic [LANES*LANE_W-1:0] lane_mask(input be_t be);
        return {{LANE_W{be[3]}}, {LANE_W{be[2]}}, {LANE_W{be[1]}}, {LANE_W{be[0]}}};
    endfunction
endpackage

// File: rtl/mem_lane_decode.sv
// mem_lane_decode: big-endian byte-lane decode for a store.
//   size     in  : access size code
//   offset   in  : addr[1:0]
//   wdata    in  : right-justified store data
//   be       out : byte enables, be[3] = bits [31:24]
//   wlane    out : store data replicated onto every lane it could occupy
//   misalign out : word not on a 4-byte boundary or half on an odd address
module mem_lane_decode
    import mem_responder_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    output be_t         be,
    output logic [31:0] wlane,
    output logic        misalign
);
    always_comb begin
        be = size == SZ_WORD ? 4'b1111 :
             size == SZ_HALF ? (offset[1] ? 4'b0011 : 4'b1100) :
             size == SZ_BYTE ? 4'b1000 >> offset : 4'b0000;
        // Replication lets the byte enables alone pick the destination lane.
        wlane = size == SZ_WORD ? wdata :
                size == SZ_HALF ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
        misalign = (size == SZ_WORD && offset != 2'b00) || (size == SZ_HALF && offset[0]);
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: word-organised memory serving one request per req/ack handshake
//   after LATENCY wait states.
//   clk, rst           : clock, asynchronous active-high reset
//   req, wr, size      : request strobe, write select, access size (sampled in IDLE)
//   addr, wdata        : byte address (big-endian lanes), right-justified store data
//   rdata              : aligned word (pre-write for stores), held between acks
//   ack, err           : one-cycle completion pulse, rejection flag with ack
//   busy               : high from the cycle after acceptance through the ack cycle
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [31:0] mem [DEPTH];
    be_t         be;
    logic [31:0] wlane, word;
    logic        misalign, bad;

    mem_lane_decode u_dec (
        .size     (size_q),
        .offset   (addr_q[1:0]),
        .wdata    (wdata_q),
        .be       (be),
        .wlane    (wlane),
        .misalign (misalign)
    );

    assign word  = mem[addr_q[AW+1:2]];
    assign bad   = size_q == SZ_RSVD || misalign || (addr_q >> (AW + 2)) != 32'd0;
    assign ack   = state == S_ACCESS;
    assign err   = ack && bad;
    assign busy  = state != S_IDLE;
    // Storage is read before the write edge, so stores return the old word.
    assign rdata = ack && !bad ? word : rdata_q;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_IDLE: if (req) begin
                state_n = LATENCY == 0 ? S_ACCESS : S_WAIT;
                cnt_n   = 4'(LATENCY);
            end
            S_WAIT: begin
                cnt_n   = cnt - 4'd1;
                state_n = cnt == 4'd1 ? S_ACCESS : S_WAIT;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            wr_q    <= 1'b0;
            size_q  <= SZ_WORD;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state == S_IDLE && req) begin
                wr_q    <= wr;
                size_q  <= size;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (ack) rdata_q <= rdata;
        end
    end

    // Writes land only on the edge leaving ACCESS, so an abandoned request never stores.
    always_ff @(posedge clk) begin
        if (ack && !bad && wr_q)
            mem[addr_q[AW+1:2]] <= (wlane & lane_mask(be)) | (word & ~lane_mask(be));
    end
endmodule
